// File: rtl/matraptor_pkg.sv
// Shared types and default widths for the row-merger datapath and its PE neighbours.
package matraptor_pkg;

  localparam int unsigned MR_DATA_W = 32;
  localparam int unsigned MR_IDX_W  = 16;
  localparam int unsigned MR_NQ     = 8;

  typedef struct packed {
    logic [MR_DATA_W-1:0] val;
    logic [MR_IDX_W-1:0]  col;
  } mr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    FLUSH,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/mr_min_col_tree.sv
// Combinational log2(NQ) reduction: smallest head column across non-empty queues,
// the mask of every queue whose head holds that column, and whether any head exists.
module mr_min_col_tree #(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned NQ    = 8
) (
  input  logic [NQ-1:0]       q_empty,
  input  logic [NQ*IDX_W-1:0] q_head_col,
  output logic [IDX_W-1:0]    min_col,
  output logic [NQ-1:0]       eq_mask,
  output logic                any_valid
);

  localparam int unsigned LVLS = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int unsigned NP   = 1 << LVLS;

  logic             nd_vld [NP];
  logic [IDX_W-1:0] nd_col [NP];
  logic [NQ-1:0]    nd_msk [NP];

  // Leaves are reduced in place, level by level; node k always reads 2k/2k+1 before
  // anything overwrites them, so this unrolls into a balanced comparator tree.
  always_comb begin
    for (int k = 0; k < int'(NP); k++) begin
      if (k < int'(NQ) && !q_empty[k]) begin
        nd_vld[k] = 1'b1;
        nd_col[k] = q_head_col[k*IDX_W +: IDX_W];
        nd_msk[k] = NQ'(1) << k;
      end else begin
        nd_vld[k] = 1'b0;
        nd_col[k] = '0;
        nd_msk[k] = '0;
      end
    end
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int k = 0; k < int'(NP / 2); k++) begin
        if (k < int'(NP >> (l + 1))) begin
          if (nd_vld[2*k] && (!nd_vld[2*k+1] || nd_col[2*k] < nd_col[2*k+1])) begin
            nd_vld[k] = 1'b1;
            nd_col[k] = nd_col[2*k];
            nd_msk[k] = nd_msk[2*k];
          end else if (nd_vld[2*k+1] && (!nd_vld[2*k] || nd_col[2*k+1] < nd_col[2*k])) begin
            nd_vld[k] = 1'b1;
            nd_col[k] = nd_col[2*k+1];
            nd_msk[k] = nd_msk[2*k+1];
          end else begin
            // Equal columns merge masks; two empty subtrees carry a zero mask.
            nd_vld[k] = nd_vld[2*k];
            nd_col[k] = nd_col[2*k];
            nd_msk[k] = nd_msk[2*k] | nd_msk[2*k+1];
          end
        end
      end
    end
    min_col   = nd_col[0];
    eq_mask   = nd_msk[0];
    any_valid = nd_vld[0];
  end

endmodule

// File: rtl/mr_row_merger.sv
// Drains one PE's column-sorted partial-product queues into a single column-ascending
// output row, summing values that share a column.
module mr_row_merger
  import matraptor_pkg::*;
#(
  parameter int unsigned DATA_W = MR_DATA_W,
  parameter int unsigned IDX_W  = MR_IDX_W,
  parameter int unsigned NQ     = MR_NQ
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IDX_W-1:0]    start_row,
  output logic                busy,
  input  logic [NQ-1:0]       q_empty,
  input  logic [NQ*DATA_W-1:0] q_head_val,
  input  logic [NQ*IDX_W-1:0] q_head_col,
  output logic [NQ-1:0]       q_pop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_val,
  output logic [IDX_W-1:0]    out_row,
  output logic [IDX_W-1:0]    out_col,
  output logic                out_last,
  output logic                done
);

  state_t            state;
  logic [IDX_W-1:0]  row_q;
  logic              busy_q;
  logic              done_q;

  logic              p_valid;
  logic [IDX_W-1:0]  p_col;
  logic [DATA_W-1:0] p_val;

  logic              o_valid;
  logic              o_last;
  logic [IDX_W-1:0]  o_col;
  logic [DATA_W-1:0] o_val;

  logic [IDX_W-1:0]  m_col;
  logic [NQ-1:0]     e_mask;
  logic              any_valid;
  logic [DATA_W-1:0] e_sum;
  logic              o_free;
  logic              can_pop;

  mr_min_col_tree #(
    .IDX_W (IDX_W),
    .NQ    (NQ)
  ) u_min_tree (
    .q_empty    (q_empty),
    .q_head_col (q_head_col),
    .min_col    (m_col),
    .eq_mask    (e_mask),
    .any_valid  (any_valid)
  );

  // Sum of every head sitting on the minimum column; wraps at DATA_W.
  always_comb begin
    e_sum = '0;
    for (int q = 0; q < int'(NQ); q++) begin
      if (e_mask[q]) begin
        e_sum = e_sum + q_head_val[q*DATA_W +: DATA_W];
      end
    end
  end

  assign o_free  = !o_valid || out_ready;
  assign can_pop = (state == MERGE) && any_valid && (!p_valid || (p_col == m_col) || o_free);
  assign q_pop   = (rst_n && can_pop) ? e_mask : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_valid <= 1'b0;
      p_col   <= '0;
      p_val   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_col   <= '0;
      o_val   <= '0;
    end else begin
      done_q <= 1'b0;
      if (o_valid && out_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            row_q   <= start_row;
            p_valid <= 1'b0;
            busy_q  <= 1'b1;
            state   <= MERGE;
          end else begin
            state <= IDLE;
          end
        end
        MERGE: begin
          if (!any_valid) begin
            state <= FLUSH;
          end else if (!p_valid) begin
            p_valid <= 1'b1;
            p_col   <= m_col;
            p_val   <= e_sum;
          end else if (p_col == m_col) begin
            p_val <= p_val + e_sum;
          end else if (o_free) begin
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            o_col   <= p_col;
            o_val   <= p_val;
            p_col   <= m_col;
            p_val   <= e_sum;
          end
        end
        FLUSH: begin
          if (!p_valid) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else if (o_free) begin
            o_valid <= 1'b1;
            o_last  <= 1'b1;
            o_col   <= p_col;
            o_val   <= p_val;
            p_valid <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (o_valid && out_ready && o_last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = o_valid;
  assign out_last  = o_last;
  assign out_val   = o_val;
  assign out_col   = o_col;
  assign out_row   = row_q;

endmodule

// File: tb/tb_mr_row_merger.sv
// Table-driven bench for mr_row_merger with a behavioural queue model and beat scoreboard.
module tb_mr_row_merger;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned NQ = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [IW-1:0]     start_row;
  logic              busy;
  logic [NQ-1:0]     q_empty;
  logic [NQ*DW-1:0]  q_head_val;
  logic [NQ*IW-1:0]  q_head_col;
  logic [NQ-1:0]     q_pop;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_val;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic              out_last;
  logic              done;

  always #5 clk = ~clk;

  mr_row_merger #(.DATA_W(DW), .IDX_W(IW), .NQ(NQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_row  (start_row),
    .busy       (busy),
    .q_empty    (q_empty),
    .q_head_val (q_head_val),
    .q_head_col (q_head_col),
    .q_pop      (q_pop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] val;
    logic [IW-1:0] col;
    logic          last;
  } beat_t;

  beat_t sb[$];

  typedef struct packed {
    logic [IW-1:0]              row;
    logic [NQ-1:0][2:0]         len;
    logic [NQ-1:0][3:0][DW-1:0] val;
    logic [NQ-1:0][3:0][IW-1:0] col;
    logic [4:0]                 nexp;
    logic [15:0][DW-1:0]        ev;
    logic [15:0][IW-1:0]        ec;
    logic [3:0]                 lat;
    logic [NQ-1:0]              pop0;
    logic [4:0]                 stall;
    logic                       poke;
  } vec_t;

  localparam int NTBL = 7;
  vec_t tbl [NTBL];

  // Behavioural queue storage; heads advance one slot per popped cycle.
  logic [DW-1:0] mv [NQ][4];
  logic [IW-1:0] mc [NQ][4];
  int            ml [NQ];
  int            hd [NQ];

  task automatic put(input int t, input int q, input logic [DW-1:0] v, input logic [IW-1:0] c);
    tbl[t].val[q][tbl[t].len[q]] = v;
    tbl[t].col[q][tbl[t].len[q]] = c;
    tbl[t].len[q] = tbl[t].len[q] + 3'd1;
  endtask

  task automatic expb(input int t, input logic [DW-1:0] v, input logic [IW-1:0] c);
    tbl[t].ev[tbl[t].nexp] = v;
    tbl[t].ec[tbl[t].nexp] = c;
    tbl[t].nexp = tbl[t].nexp + 5'd1;
  endtask

  task automatic build_table();
    for (int t = 0; t < NTBL; t++) tbl[t] = '0;
    // single queue
    tbl[0].row = 16'd4; tbl[0].lat = 4'd2; tbl[0].pop0 = 8'h01;
    put(0, 0, 32'd10, 16'd1); put(0, 0, 32'd20, 16'd3); put(0, 0, 32'd30, 16'd5);
    expb(0, 32'd10, 16'd1); expb(0, 32'd20, 16'd3); expb(0, 32'd30, 16'd5);
    // three-way collision
    tbl[1].row = 16'd7; tbl[1].lat = 4'd3; tbl[1].pop0 = 8'h07;
    put(1, 0, 32'd5, 16'd2); put(1, 1, 32'd7, 16'd2); put(1, 2, 32'hFFFF_FFFD, 16'd2);
    expb(1, 32'd9, 16'd2);
    // interleave, with a start pulse while busy
    tbl[2].row = 16'd9; tbl[2].lat = 4'd2; tbl[2].pop0 = 8'h01; tbl[2].poke = 1'b1;
    put(2, 0, 32'd1, 16'd1); put(2, 0, 32'd2, 16'd4);
    put(2, 1, 32'd3, 16'd2); put(2, 1, 32'd4, 16'd4); put(2, 1, 32'd5, 16'd6);
    expb(2, 32'd1, 16'd1); expb(2, 32'd3, 16'd2); expb(2, 32'd6, 16'd4); expb(2, 32'd5, 16'd6);
    // interleave under backpressure
    tbl[3] = tbl[2];
    tbl[3].poke = 1'b0; tbl[3].stall = 5'd10; tbl[3].row = 16'd12;
    // empty row
    tbl[4].row = 16'd2;
    // overflow wrap and zero-valued sum
    tbl[5].row = 16'h00AB; tbl[5].lat = 4'd2; tbl[5].pop0 = 8'h48;
    put(5, 3, 32'h7FFF_FFFF, 16'd5); put(5, 6, 32'h0000_0001, 16'd5);
    put(5, 4, 32'd5, 16'd9); put(5, 5, 32'hFFFF_FFFB, 16'd9);
    expb(5, 32'h8000_0000, 16'd5); expb(5, 32'd0, 16'd9);
    // all eight queues: distinct columns then an eight-way collision
    tbl[6].row = 16'h1234; tbl[6].lat = 4'd2; tbl[6].pop0 = 8'h01;
    for (int q = 0; q < int'(NQ); q++) begin
      put(6, q, DW'(q), IW'(q));
      put(6, q, 32'd1, 16'd20);
      expb(6, DW'(q), IW'(q));
    end
    expb(6, 32'd8, 16'd20);
  endtask

  task automatic drive_heads();
    for (int q = 0; q < int'(NQ); q++) begin
      if (hd[q] < ml[q]) begin
        q_empty[q] = 1'b0;
        q_head_val[q*DW +: DW] = mv[q][hd[q]];
        q_head_col[q*IW +: IW] = mc[q][hd[q]];
      end else begin
        q_empty[q] = 1'b1;
        q_head_val[q*DW +: DW] = 32'hDEAD_BEEF;
        q_head_col[q*IW +: IW] = '0;
      end
    end
  endtask

  task automatic advance(input logic [NQ-1:0] p);
    for (int q = 0; q < int'(NQ); q++) if (p[q]) hd[q]++;
    drive_heads();
  endtask

  task automatic run_case(input int t);
    vec_t          v;
    beat_t         b;
    logic [NQ-1:0] popped;
    logic [DW+IW:0] held;
    logic          stalled_prev, done_seen, drained;
    int            n0, first_valid, first_pop, pops, last_hs, beats, stall_left, exp_done;
    v = tbl[t];
    for (int q = 0; q < int'(NQ); q++) begin
      ml[q] = int'(v.len[q]);
      hd[q] = 0;
      for (int s = 0; s < 4; s++) begin
        mv[q][s] = v.val[q][s];
        mc[q][s] = v.col[q][s];
      end
    end
    drive_heads();
    for (int k = 0; k < int'(v.nexp); k++) begin
      b.val  = v.ev[k];
      b.col  = v.ec[k];
      b.last = (k == int'(v.nexp) - 1);
      sb.push_back(b);
    end
    out_ready = 1'b1;
    start_row = v.row;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_row = ~v.row;
    n0 = cyc;
    first_valid = -1; first_pop = -1; pops = 0; last_hs = -1; beats = 0;
    stall_left = 0; stalled_prev = 1'b0; done_seen = 1'b0; held = '0;
    for (int i = 0; i < 300 && !done_seen; i++) begin
      @(negedge clk);
      popped = q_pop;
      if (q_pop != '0) begin
        if (first_pop < 0) begin
          first_pop = cyc;
          chk($sformatf("c%0d first_pop_mask", t), 64'(q_pop), 64'(v.pop0));
          chk($sformatf("c%0d first_pop_cycle", t), 64'(cyc - n0), 64'(0));
        end
        pops++;
        chk($sformatf("c%0d pop_of_empty", t), 64'(q_pop & q_empty), 64'(0));
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (v.lat != '0) chk($sformatf("c%0d first_valid_cycle", t), 64'(cyc - n0), 64'(v.lat));
      end
      if (stalled_prev) chk($sformatf("c%0d hold_stable", t), 64'({out_valid, out_val, out_col, out_last}),
                            64'({1'b1, held}));
      if (!out_ready) chk($sformatf("c%0d pop_while_stalled", t), 64'(q_pop), 64'(0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk($sformatf("c%0d extra_beat", t), 64'(1), 64'(0));
        end else begin
          b = sb.pop_front();
          chk($sformatf("c%0d beat_val", t), 64'(out_val), 64'(b.val));
          chk($sformatf("c%0d beat_col", t), 64'(out_col), 64'(b.col));
          chk($sformatf("c%0d beat_last", t), 64'(out_last), 64'(b.last));
          chk($sformatf("c%0d beat_row", t), 64'(out_row), 64'(v.row));
        end
        last_hs = cyc;
        beats++;
        if (beats == 1 && v.stall != '0) stall_left = int'(v.stall);
      end
      held = {out_val, out_col, out_last};
      stalled_prev = out_valid && !out_ready;
      if (done) begin
        done_seen = 1'b1;
        exp_done  = (v.nexp == '0) ? n0 + 2 : last_hs + 1;
        chk($sformatf("c%0d done_cycle", t), 64'(cyc), 64'(exp_done));
        chk($sformatf("c%0d busy_at_done", t), 64'(busy), 64'(0));
      end else begin
        chk($sformatf("c%0d busy", t), 64'(busy), 64'(1));
      end
      if (v.poke && i == 1) begin
        start     = 1'b1;
        start_row = 16'hBEEF;
      end
      @(posedge clk); #1;
      advance(popped);
      start = 1'b0;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    if (!done_seen) chk($sformatf("c%0d done_timeout", t), 64'(0), 64'(1));
    chk($sformatf("c%0d beat_count", t), 64'(beats), 64'(v.nexp));
    chk($sformatf("c%0d pop_cycles", t), 64'(pops), 64'(v.nexp));
    chk($sformatf("c%0d beats_left", t), 64'(sb.size()), 64'(0));
    drained = 1'b1;
    for (int q = 0; q < int'(NQ); q++) if (hd[q] != ml[q]) drained = 1'b0;
    chk($sformatf("c%0d drained", t), 64'(drained), 64'(1));
    @(negedge clk);
    chk($sformatf("c%0d idle_after", t), 64'({busy, out_valid}), 64'(0));
    sb.delete();
  endtask

  logic [NQ-1:0] rp;
  logic          got;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_row = '0; out_ready = 1'b1;
    q_empty = '1; q_head_val = '0; q_head_col = '0;
    for (int q = 0; q < int'(NQ); q++) begin ml[q] = 0; hd[q] = 0; end
    drive_heads();
    build_table();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({busy, out_valid, out_last, done, q_pop}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < NTBL; t++) run_case(t);

    // Reset asserted while the final beat is held in DRAIN.
    for (int q = 0; q < int'(NQ); q++) begin ml[q] = 0; hd[q] = 0; end
    ml[0] = 1; mv[0][0] = 32'd11; mc[0][0] = 16'd3;
    drive_heads();
    out_ready = 1'b0; start_row = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      rp = q_pop;
      if (out_valid && out_last) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        advance(rp);
      end
    end
    chk("rst_reach_drain", 64'(got), 64'(1));
    chk("rst_drain_val", 64'(out_val), 64'(11));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pop_low", 64'(q_pop), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_outputs_cleared", 64'({out_valid, out_last, busy, done}), 64'(0));
    @(posedge clk); #1;
    run_case(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mr_row_merger.md
Name: mr_row_merger

Overview:
- Downstream neighbour of the PE fill stage. After a PE signals row_done, this block drains that PE's NQ column-sorted partial-product queues.
- Each cycle it selects the minimum column across queue heads and pops every head holding that column. Equal-column values are summed.
- It emits one output row as a column-ascending (val,row,col,last) stream over ready/valid.
- One instance per PE; outputs feed the output writer/arbiter.

Parameters:
- DATA_W, 32, width of value; two's-complement integer, wraps on overflow.
- IDX_W, 16, width of row/col index.
- NQ, 8, number of input queues.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin merging a row; accepted only when busy=0
- start_row  in  IDX_W  row index, captured on accepted start
- busy  out  1  high from accepted start until done
- q_empty  in  NQ  per-queue empty flag
- q_head_val  in  NQ*DATA_W  head value, queue q at [q*DATA_W +: DATA_W]
- q_head_col  in  NQ*IDX_W  head column, packed likewise
- q_pop  out  NQ  combinational pop; the head advances on the next cycle
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_val  out  DATA_W  merged value
- out_row  out  IDX_W  captured start_row
- out_col  out  IDX_W  column
- out_last  out  1  final beat of the row
- done  out  1  one-cycle pulse at end of row

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; busy, q_pop, out_valid, out_last and done are 0.
  - The P register and O register are invalidated.
  - Reset mid-merge abandons the row and drops in-flight data; q_pop=0 during reset.
- Input contract: each queue is ascending by col with no duplicates inside a queue. Queue contents are frozen for the whole merge.
- Internal state: P = pending accumulator {valid, col, val}; O = output register driving out_*.
- FSM IDLE:
  - start=1 captures start_row; next state MERGE; busy=1 next cycle.
- FSM MERGE, per cycle:
  - m = min q_head_col over non-empty queues; E = mask of non-empty heads with col==m; S = sum of E values (DATA_W wrap).
  - If P invalid: q_pop=E, P<={1,m,S}.
  - Else if P.col==m: q_pop=E, P.val<=P.val+S.
  - Else, when O is free (O empty, or out_valid&&out_ready this cycle): q_pop=E, O<=P with last=0, P<={1,m,S}.
  - Else stall: q_pop=0, P unchanged.
  - All q_empty: go to FLUSH. No pop in that cycle.
- FSM FLUSH:
  - P valid: move P into O with last=1 as soon as O is free; then DRAIN.
  - P invalid (empty row): go to FIN directly; no output beat.
- FSM DRAIN: wait for the out_last handshake, then FIN.
- FSM FIN: done=1 and busy=0 for this one cycle; next IDLE.
- start while busy is ignored and has no side effects.
- out_* hold stable while out_valid&&!out_ready.
- Throughput: one distinct column per cycle when out_ready=1.
- Latency: accepted start at T gives first q_pop at T+1 and earliest out_valid at T+3.
- Zero-valued sums are emitted, not filtered.
- out_row is constant for the row and equals the captured start_row.

Decomposition:
- matraptor_pkg holds:
  - default DATA_W/IDX_W localparams
  - typedef struct packed {val, col} mr_entry_t, shared with the PE queue_mem
  - typedef enum merger state_t {IDLE, MERGE, FLUSH, DRAIN, FIN}
- One sub-module: mr_min_col_tree. It is a combinational log2(NQ) reduction over (q_empty, q_head_col) producing min col m, equal-mask E and any_valid. The value sum stays in mr_row_merger.

Test Plan:
1. Single queue, out_ready=1: q0={(10,c1),(20,c3),(30,c5)}, start_row=4 -> beats (10,4,1,0),(20,4,3,0),(30,4,5,1). Then done one cycle after the last handshake, busy=0.
2. Three-way collision: q0={(5,c2)}, q1={(7,c2)}, q2={(-3,c2)} -> one q_pop cycle with q_pop=0b00000111, then a single beat (9,r,2,last=1).
3. Interleave: q0={(1,c1),(2,c4)}, q1={(3,c2),(4,c4),(5,c6)} -> beats col1=1, col2=3, col4=6, col6=5 (last). Cols strictly ascending.
4. Backpressure: scenario 3 with out_ready=0 for 10 cycles after the first beat. Required:
   - out_* stable throughout.
   - q_pop=0 once P and O are both full.
   - Identical beat sequence after release; no loss or duplication.
5. Empty row: all q_empty=1 at start -> out_valid never asserted; done pulses at T+3 (MERGE, FLUSH, FIN); no q_pop.
6. Robustness:
   - start pulsed while busy has no effect.
   - 0x7FFFFFFF + 0x00000001 on the same column yields 0x80000000.
   - rst_n low mid-DRAIN gives out_valid=0 and state IDLE next cycle; a new start then merges correctly.
